// File: rtl/tia_horizontal_motion_generator_pkg.sv
// Shared constants and helpers for the TIA horizontal motion generator:
// object indices, the HMCLR address, burst length and the compare bias.
package tia_horizontal_motion_generator_pkg;

  localparam int NUM_OBJECTS = 5;
  localparam int HMCLR_ADDR  = 5;
  localparam int NUM_STEPS   = 15;

  typedef enum logic [2:0] {
    OBJ_P0 = 3'd0,
    OBJ_P1 = 3'd1,
    OBJ_M0 = 3'd2,
    OBJ_M1 = 3'd3,
    OBJ_BL = 3'd4
  } obj_e;

  // Flipping the sign bit maps the -8..+7 motion value onto a 0..15 pulse count.
  localparam logic [3:0] HM_BIAS = 4'b1000;

  function automatic logic [3:0] hm_to_cmp(input logic [3:0] hm);
    return hm ^ HM_BIAS;
  endfunction

endpackage

// File: rtl/tia_horizontal_motion_generator_compare.sv
// Per-object motion compare: enable latch armed at burst start, dropped when
// the step count reaches the object's compare value, gating one mec_bar line.
module tia_motion_compare
  import tia_horizontal_motion_generator_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hm_i,
  input  logic [3:0] cnt_i,
  input  logic       start_i,
  input  logic       step_i,
  output logic       mec_bar_o
);

  logic [3:0] cmp;
  logic [3:0] cnt_nxt;
  logic       en_q;

  // Compare uses the live register, so a mid-burst write can skip the match.
  assign cmp     = hm_to_cmp(hm_i);
  assign cnt_nxt = cnt_i + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q <= 1'b0;
    end else if (start_i) begin
      en_q <= (cmp != 4'd0);
    end else if (step_i && ((cnt_nxt == 4'(NUM_STEPS)) || (cnt_nxt == cmp))) begin
      en_q <= 1'b0;
    end
  end

  assign mec_bar_o = ~(step_i & en_q);

endmodule

// File: rtl/tia_horizontal_motion_generator.sv
// HM fine-motion registers, HMOVE burst sequencing and extended-HBLANK latch;
// drives one active-low extra-clock line per movable object.
module tia_horizontal_motion_generator
  import tia_horizontal_motion_generator_pkg::*;
#(
  parameter int N_OBJ = NUM_OBJECTS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             motck,
  input  logic             hmove,
  input  logic             hblank_end,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [3:0]       wr_data,
  output logic [N_OBJ-1:0] mec_bar,
  output logic             motion_active,
  output logic             hblank_ext
);

  logic [N_OBJ-1:0][3:0] hm_q, hm_d;
  logic [3:0]            cnt_q, cnt_d, cnt_nxt;
  logic                  pending_q, pending_d;
  logic                  active_q, active_d;
  logic                  hbx_q, hbx_d;
  logic                  start, step;

  // A pending restart takes priority over stepping the running burst.
  assign start   = motck & pending_q;
  assign step    = motck & active_q & ~pending_q;
  assign cnt_nxt = cnt_q + 4'd1;

  always_comb begin
    hm_d      = hm_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    pending_d = hmove | (pending_q & ~motck);
    hbx_d     = hmove | (hbx_q & ~hblank_end);
    if (wr_en) begin
      if (wr_addr == 3'(HMCLR_ADDR)) hm_d = '0;
      for (int i = 0; i < N_OBJ; i++)
        if (wr_addr == 3'(i)) hm_d[i] = wr_data;
    end
    if (start) begin
      cnt_d    = 4'd0;
      active_d = 1'b1;
    end else if (step) begin
      cnt_d = cnt_nxt;
      if (cnt_nxt == 4'(NUM_STEPS)) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hm_q      <= '0;
      cnt_q     <= 4'd0;
      pending_q <= 1'b0;
      active_q  <= 1'b0;
      hbx_q     <= 1'b0;
    end else begin
      hm_q      <= hm_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      hbx_q     <= hbx_d;
    end
  end

  for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
    tia_motion_compare u_cmp (
      .clk      (clk),
      .reset    (reset),
      .hm_i     (hm_q[g]),
      .cnt_i    (cnt_q),
      .start_i  (start),
      .step_i   (step),
      .mec_bar_o(mec_bar[g])
    );
  end

  assign motion_active = active_q;
  assign hblank_ext    = hbx_q;

endmodule

// File: tb/tb_tia_horizontal_motion_generator.sv
// Directed bench for the motion generator: a burst-level model checked every
// cycle, plus literal pulse counts per object for each scenario.
module tb_tia_horizontal_motion_generator;
  localparam int NO = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0, motck = 1'b0, hmove = 1'b0, hblank_end = 1'b0;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_addr = '0;
  logic [3:0]    wr_data = '0;
  logic [NO-1:0] mec_bar;
  logic          motion_active, hblank_ext;

  tia_horizontal_motion_generator dut (
    .clk(clk), .reset(reset), .motck(motck), .hmove(hmove),
    .hblank_end(hblank_end), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .mec_bar(mec_bar), .motion_active(motion_active),
    .hblank_ext(hblank_ext)
  );

  always #5 clk = ~clk;

  int nchk = 0, npass = 0;
  int phase = 0;
  int pc[NO];

  // Model: motion values, pending flag, steps completed in the burst
  // (-1 = idle), and which objects have already reached their pulse count.
  int  m_hm[NO];
  bit  m_stop[NO];
  bit  m_pend, m_hbx, m_valid;
  int  m_steps = -1;

  function automatic int cval(input int hm);
    return (hm >= 8) ? hm - 8 : hm + 8;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic clr_counts();
    for (int i = 0; i < NO; i++) pc[i] = 0;
  endtask

  task automatic cyc(input logic rst, input logic hmv, input logic he,
                     input logic we, input logic [2:0] wa, input logic [3:0] wd);
    bit st, sp;
    int exp_mec;
    reset = rst; hmove = hmv; hblank_end = he;
    wr_en = we; wr_addr = wa; wr_data = wd;
    motck = (phase == 3);
    phase = (phase + 1) % 4;
    @(negedge clk);
    st = motck && m_pend;
    sp = motck && (m_steps >= 0) && !m_pend;
    if (m_valid) begin
      exp_mec = 0;
      for (int i = 0; i < NO; i++)
        if (!(sp && !m_stop[i])) exp_mec |= (1 << i);
      chk("mec_bar", int'(mec_bar), exp_mec);
      chk("motion_active", int'(motion_active), int'(m_steps >= 0));
      chk("hblank_ext", int'(hblank_ext), int'(m_hbx));
    end
    for (int i = 0; i < NO; i++) if (!mec_bar[i]) pc[i]++;
    if (rst) begin
      for (int i = 0; i < NO; i++) begin m_hm[i] = 0; m_stop[i] = 1'b1; end
      m_pend = 1'b0; m_hbx = 1'b0; m_steps = -1; m_valid = 1'b1;
    end else begin
      if (sp) begin
        m_steps++;
        for (int i = 0; i < NO; i++) if (m_steps == cval(m_hm[i])) m_stop[i] = 1'b1;
        if (m_steps == 15) m_steps = -1;
      end
      if (st) begin
        m_steps = 0;
        for (int i = 0; i < NO; i++) m_stop[i] = (cval(m_hm[i]) == 0);
      end
      m_pend = hmv || (m_pend && !motck);
      m_hbx  = hmv || (m_hbx && !he);
      if (we && wa == 3'd5) for (int i = 0; i < NO; i++) m_hm[i] = 0;
      else if (we && wa < 3'd5) m_hm[wa] = int'(wd);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 3'd0, 4'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d);
    cyc(0, 0, 0, 1, a, d);
  endtask

  task automatic run_motck(input int n);
    int k = 0;
    while (k < n) begin
      if (phase == 3) k++;
      cyc(0, 0, 0, 0, 3'd0, 4'd0);
    end
  endtask

  task automatic chk_counts(input string nm, input int e0, input int e1,
                            input int e2, input int e3, input int e4);
    int e[NO];
    e = '{e0, e1, e2, e3, e4};
    for (int i = 0; i < NO; i++) chk($sformatf("%s obj%0d pulses", nm, i), pc[i], e[i]);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 3'd0, 4'd0);
    chk("reset motion_active", int'(motion_active), 0);
    chk("reset hblank_ext", int'(hblank_ext), 0);
    chk("reset mec_bar", int'(mec_bar), 31);

    // +7 on P0, zero elsewhere
    wr(3'd0, 4'b0111);
    clr_counts();
    cyc(0, 1, 0, 0, 3'd0, 4'd0);
    run_motck(20);
    chk_counts("t1", 15, 8, 8, 8, 8);
    chk("t1 burst over", int'(motion_active), 0);

    // -8 on BL gives no pulses; then HMCLR
    wr(3'd4, 4'b1000);
    clr_counts();
    cyc(0, 1, 0, 0, 3'd0, 4'd0);
    run_motck(20);
    chk_counts("t2a", 15, 8, 8, 8, 0);
    wr(3'd5, 4'd0);
    clr_counts();
    cyc(0, 1, 0, 0, 3'd0, 4'd0);
    run_motck(20);
    chk_counts("t2b", 8, 8, 8, 8, 8);

    // Rewrite M0 to -8 after 5 steps: match is missed, pulses through step 15
    clr_counts();
    cyc(0, 1, 0, 0, 3'd0, 4'd0);
    run_motck(6);
    wr(3'd2, 4'b1000);
    run_motck(15);
    chk_counts("t3 artifact", 8, 8, 15, 8, 8);
    wr(3'd6, 4'b0111);
    clr_counts();
    cyc(0, 1, 0, 0, 3'd0, 4'd0);
    run_motck(20);
    chk_counts("t3 addr6", 8, 8, 0, 8, 8);

    // Restart mid-burst
    wr(3'd5, 4'd0);
    wr(3'd1, 4'b0111);
    clr_counts();
    cyc(0, 1, 0, 0, 3'd0, 4'd0);
    run_motck(6);
    cyc(0, 1, 0, 0, 3'd0, 4'd0);
    run_motck(20);
    chk_counts("t4 restart", 13, 20, 13, 13, 13);

    // hmove coincident with motck: start waits for the following motck
    while (phase != 3) idle(1);
    cyc(0, 1, 0, 0, 3'd0, 4'd0);
    chk("t4 no start on hmove edge", int'(motion_active), 0);
    idle(3);
    chk("t4 still idle", int'(motion_active), 0);
    idle(1);
    chk("t4 start next motck", int'(motion_active), 1);
    run_motck(16);

    // Reset mid-burst
    clr_counts();
    cyc(0, 1, 0, 0, 3'd0, 4'd0);
    run_motck(7);
    cyc(1, 0, 0, 0, 3'd0, 4'd0);
    chk("t5 active after reset", int'(motion_active), 0);
    chk("t5 hblank_ext after reset", int'(hblank_ext), 0);
    chk("t5 mec_bar after reset", int'(mec_bar), 31);
    clr_counts();
    run_motck(20);
    chk_counts("t5 quiet", 0, 0, 0, 0, 0);
    clr_counts();
    cyc(0, 1, 0, 0, 3'd0, 4'd0);
    run_motck(20);
    chk_counts("t5 hm cleared", 8, 8, 8, 8, 8);

    // Extended HBLANK latch
    cyc(0, 1, 0, 0, 3'd0, 4'd0);
    chk("t6 hbx set", int'(hblank_ext), 1);
    cyc(0, 0, 1, 0, 3'd0, 4'd0);
    chk("t6 hbx clear", int'(hblank_ext), 0);
    cyc(0, 1, 1, 0, 3'd0, 4'd0);
    chk("t6 set wins", int'(hblank_ext), 1);
    cyc(0, 0, 1, 0, 3'd0, 4'd0);
    chk("t6 hbx clear again", int'(hblank_ext), 0);
    run_motck(20);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
